// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pkg
// Purpose  : Shared constants and the FIFO entry type for the instruction
//            fetch unit.
// Contents : ADDR_W, INSTR_W, RESET_PC, fetch_entry_t {pc, instr}
// Revision : 1.0  initial release
// ============================================================================
package fetch_pkg;

  localparam int          ADDR_W   = 8;
  localparam int          INSTR_W  = 24;
  localparam logic [7:0]  RESET_PC = 8'h00;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage : fetch_pkg
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fetch_fifo
// Purpose  : 2-entry FIFO holding fetched {pc, instr} pairs. Entry 0 is
//            always the head; a pop shifts entry 1 down.
// Ports    : clk, rst_n          clock, async active-low reset
//            push, push_data     write one entry (ignored when full and no pop)
//            pop                 remove head (ignored when empty)
//            flush               discard all entries (wins over push/pop)
//            count               number of valid entries, 0..2
//            head                entry at the FIFO head
// Revision : 1.0  initial release
// ============================================================================
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter type ENTRY_T = fetch_entry_t
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  ENTRY_T     push_data,
  input  logic       pop,
  input  logic       flush,
  output logic [1:0] count,
  output ENTRY_T     head
);

  ENTRY_T     entry0_q;
  ENTRY_T     entry1_q;
  logic [1:0] count_q;
  logic       pop_ok;
  logic       push_ok;

  assign pop_ok  = pop & (count_q != 2'd0);
  assign push_ok = push & ((count_q != 2'd2) | pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry0_q <= '0;
      entry1_q <= '0;
      count_q  <= 2'd0;
    end else if (flush) begin
      count_q <= 2'd0;
    end else if (push_ok && pop_ok) begin
      // Count unchanged; new data lands behind whatever remains.
      if (count_q == 2'd2) begin
        entry0_q <= entry1_q;
        entry1_q <= push_data;
      end else begin
        entry0_q <= push_data;
      end
    end else if (push_ok) begin
      if (count_q == 2'd0) begin
        entry0_q <= push_data;
      end else begin
        entry1_q <= push_data;
      end
      count_q <= count_q + 2'd1;
    end else if (pop_ok) begin
      entry0_q <= entry1_q;
      count_q  <= count_q - 2'd1;
    end
  end

  assign count = count_q;
  assign head  = entry0_q;

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Read-side master for the instruction memory. Owns the PC,
//            absorbs the one-cycle synchronous read latency and delivers
//            (pc, instr) pairs to decode over valid/ready. Supports redirect
//            with flush, fetch enable and backpressure.
// Ports    : clk, rst_n               clock, async active-low reset
//            fetch_en                 permit new memory reads
//            redirect_valid/_pc       load new PC, flush all fetched work
//            mem_addr                 memory address (= registered PC)
//            mem_rdata                memory data, one cycle after address
//            instr_valid/_ready       decode handshake
//            instr_data, instr_pc     head instruction and its address
// Revision : 1.0  initial release
// ============================================================================
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W   = fetch_pkg::ADDR_W,
  parameter int                 INSTR_W  = fetch_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0]  RESET_PC = fetch_pkg::RESET_PC
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [INSTR_W-1:0] mem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr_data,
  output logic [ADDR_W-1:0]  instr_pc
);

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] inf_pc_q;
  logic              inf_q;
  logic [1:0]        count;
  entry_t            head;
  entry_t            push_data;
  logic              pop;
  logic              push;
  logic              issue;
  logic [2:0]        occupancy;

  assign pop = instr_valid & instr_ready;

  // Entries stored plus the read in flight must leave room for a new read
  // after this cycle's pop, so a full FIFO can never be pushed.
  assign occupancy = {1'b0, count} + {2'b00, inf_q};
  assign issue     = fetch_en & ~redirect_valid
                   & (occupancy < (3'd2 + {2'b00, pop}));

  // A redirect discards the result of the read currently in flight.
  assign push           = inf_q & ~redirect_valid;
  assign push_data.pc    = inf_pc_q;
  assign push_data.instr = mem_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= RESET_PC;
      inf_pc_q <= '0;
      inf_q    <= 1'b0;
    end else if (redirect_valid) begin
      pc_q  <= redirect_pc;
      inf_q <= 1'b0;
    end else if (issue) begin
      inf_q    <= 1'b1;
      inf_pc_q <= pc_q;
      pc_q     <= pc_q + ADDR_W'(1);
    end else begin
      inf_q <= 1'b0;
    end
  end

  fetch_fifo #(
    .ENTRY_T (entry_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head      (head)
  );

  assign mem_addr    = pc_q;
  assign instr_valid = (count != 2'd0);
  assign instr_data  = head.instr;
  assign instr_pc    = head.pc;

endmodule : instr_fetch_unit
`default_nettype wire
